// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared entry type and register-write rule for the writeback stage
package wb_pkg;

  localparam int ADDR_WIDTH_D = 5;
  localparam int DATA_WIDTH_D = 32;

  typedef struct packed {
    logic                    regW;
    logic [ADDR_WIDTH_D-1:0] addr;
    logic [DATA_WIDTH_D-1:0] data;
  } wb_entry_t;

  // x0 is hardwired, so writes to it are dropped rather than emitted
  function automatic logic is_rf_write(input wb_entry_t e);
    return e.regW && (e.addr != '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular result buffer with head output and flat entry export
// Caller guarantees no push when full and no pop when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int WIDTH = 1 + ADDR_WIDTH_D + DATA_WIDTH_D,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [CNT_W-1:0]       o_count,
  output logic [PTR_W-1:0]       o_rd_ptr,
  output logic [WIDTH-1:0]       o_head,
  output logic [DEPTH*WIDTH-1:0] o_mem
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  // Payload needs no reset: the count alone decides which slots are live
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count  = r_count;
  assign o_rd_ptr = r_rd_ptr;
  assign o_head   = r_mem[r_rd_ptr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign o_mem[g*WIDTH +: WIDTH] = r_mem[g];
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: result FIFO, register-file drain, retire counter
// Define WB_FWD_EN to enable the bypass lookup port (q_hit/q_data).
module wb_stage
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic                  m_regW,
  input  logic [ADDR_WIDTH-1:0] m_regAddr,
  input  logic [DATA_WIDTH-1:0] m_regData,
  input  logic                  rf_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] q_addr,
  output logic                  q_hit,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic [CNT_WIDTH-1:0]  instret
);

  localparam int EW    = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]       w_count;
  logic [PTR_W-1:0]       w_rd_ptr;
  logic [EW-1:0]          w_head;
  logic [DEPTH*EW-1:0]    w_mem;
  logic                   w_head_regw;
  logic [ADDR_WIDTH-1:0]  w_head_addr;
  logic [DATA_WIDTH-1:0]  w_head_data;
  logic                   w_nonempty;
  logic                   w_needs_write;
  logic                   w_push;
  logic                   w_pop;
  logic [CNT_WIDTH-1:0]   r_instret;

  wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_data   ({m_regW, m_regAddr, m_regData}),
    .i_pop    (w_pop),
    .o_count  (w_count),
    .o_rd_ptr (w_rd_ptr),
    .o_head   (w_head),
    .o_mem    (w_mem)
  );

  assign {w_head_regw, w_head_addr, w_head_data} = w_head;
  assign w_nonempty = (w_count != '0);

  // Only whether the index is x0 matters, so it is folded to one bit for any ADDR_WIDTH
  assign w_needs_write = is_rf_write(wb_entry_t'{regW: w_head_regw,
                                                 addr: ADDR_WIDTH_D'(|w_head_addr),
                                                 data: '0});

  assign m_ready  = !rst && (w_count < CNT_W'(DEPTH));
  assign w_push   = m_valid && m_ready;
  assign w_pop    = w_nonempty && (rf_ready || !w_needs_write);

  assign rf_wen   = w_nonempty && w_needs_write;
  assign rf_waddr = w_nonempty ? w_head_addr : '0;
  assign rf_wdata = w_nonempty ? w_head_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_instret <= '0;
    else if (w_pop) r_instret <= r_instret + 1'b1;
  end

  assign instret = r_instret;

`ifdef WB_FWD_EN
  logic [PTR_W-1:0] w_idx;
  logic [EW-1:0]    w_ent;

  // Walk oldest to youngest so the youngest match is the one left standing
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    w_idx  = '0;
    w_ent  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PTR_W'(k);
      w_ent = w_mem[int'(w_idx)*EW +: EW];
      if ((CNT_W'(k) < w_count) && w_ent[EW-1] &&
          (w_ent[EW-2 -: ADDR_WIDTH] == q_addr) && (q_addr != '0)) begin
        q_hit  = 1'b1;
        q_data = w_ent[DATA_WIDTH-1:0];
      end
    end
  end
`else
  logic w_unused_fwd;

  assign q_hit        = 1'b0;
  assign q_data       = '0;
  assign w_unused_fwd = ^{q_addr, w_rd_ptr, w_mem};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a queue-based model
module tb_wb_stage;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_valid;
  logic          m_ready;
  logic          m_regW;
  logic [AW-1:0] m_regAddr;
  logic [DW-1:0] m_regData;
  logic          rf_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] q_addr;
  logic          q_hit;
  logic [DW-1:0] q_data;
  logic [CW-1:0] instret;

  wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_regW    (m_regW),
    .m_regAddr (m_regAddr),
    .m_regData (m_regData),
    .rf_ready  (rf_ready),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .q_addr    (q_addr),
    .q_hit     (q_hit),
    .q_data    (q_data),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          regw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic [CW-1:0] m_instret = '0;
  int            n_checks  = 0;
  int            n_fail    = 0;
  int            cyc       = 0;
  bit            chk_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit writes_rf(input ent_t e);
    return e.regw && (e.addr != '0);
  endfunction

  // Advance one clock; the model retires/accepts using the inputs held across the edge
  task automatic tick();
    bit do_pop;
    bit do_push;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      do_pop  = (mq.size() > 0) && (rf_ready || !writes_rf(mq[0]));
      do_push = m_valid && (mq.size() < DEPTH);
      if (do_pop) begin
        void'(mq.pop_front());
        m_instret = m_instret + 1;
      end
      if (do_push) mq.push_back('{m_regW, m_regAddr, m_regData});
    end
    #1;
  endtask

  task automatic push_item(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int guard;
    guard     = 0;
    m_valid   = 1'b1;
    m_regW    = w;
    m_regAddr = a;
    m_regData = d;
    while (!m_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: m_ready stayed 0 for %0d cycles", guard);
    end
    tick();
    m_valid = 1'b0;
  endtask

  always @(negedge clk) begin : compare
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_hit;
    logic [DW-1:0] e_qd;
    if (chk_en) begin
      e_wen  = (mq.size() > 0) && writes_rf(mq[0]);
      e_addr = (mq.size() > 0) ? mq[0].addr : '0;
      e_data = (mq.size() > 0) ? mq[0].data : '0;
      e_hit  = 1'b0;
      e_qd   = '0;
`ifdef WB_FWD_EN
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].regw && mq[i].addr == q_addr && q_addr != '0) begin
          e_hit = 1'b1;
          e_qd  = mq[i].data;
          break;
        end
      end
`endif
      check("m_ready",  m_ready,  !rst && (mq.size() < DEPTH));
      check("rf_wen",   rf_wen,   e_wen);
      check("rf_waddr", rf_waddr, e_addr);
      check("rf_wdata", rf_wdata, e_data);
      check("q_hit",    q_hit,    e_hit);
      check("q_data",   q_data,   e_qd);
      check("instret",  instret,  m_instret);
    end
  end

  initial begin
    int c0;
    rst       = 1'b1;
    m_valid   = 1'b0;
    m_regW    = 1'b0;
    m_regAddr = '0;
    m_regData = '0;
    rf_ready  = 1'b1;
    q_addr    = '0;
    #1;
    check("rst_m_ready", m_ready, 0);
    check("rst_rf_wen",  rf_wen,  0);
    check("rst_instret", instret, 0);
    check("rst_q_hit",   q_hit,   0);
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_m_ready", m_ready, 1);

    // Single write: visible the cycle after acceptance, gone after the next edge
    push_item(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("t1_wen",   rf_wen,   1);
    check("t1_waddr", rf_waddr, 5);
    check("t1_wdata", rf_wdata, 32'hDEADBEEF);
    check("t1_instret_before", instret, 0);
    tick();
    check("t1_wen_after", rf_wen,  0);
    check("t1_instret",   instret, 1);

    // x0 write and non-writing entry retire without rf_ready
    rf_ready = 1'b0;
    push_item(1'b1, 5'd0, 32'h1234);
    #1;
    check("t2_wen_x0", rf_wen, 0);
    push_item(1'b0, 5'd7, 32'h55);
    #1;
    check("t2_wen_nowrite", rf_wen,  0);
    check("t2_instret_mid", instret, 2);
    tick();
    check("t2_instret", instret, 3);

    // Backpressure: two accepted, third held until the register file drains
    m_valid = 1'b1; m_regW = 1'b1; m_regAddr = 5'd1; m_regData = 32'h101;
    tick();
    m_regAddr = 5'd2; m_regData = 32'h102;
    tick();
    m_regAddr = 5'd3; m_regData = 32'h103;
    #1;
    check("t3_full_ready", m_ready,  0);
    check("t3_head_x1",    rf_waddr, 1);
    tick();
    check("t3_still_full", m_ready,  0);
    check("t3_held_x1",    rf_waddr, 1);
    rf_ready = 1'b1;
    tick();
    check("t3_head_x2",  rf_waddr, 2);
    check("t3_ready_x3", m_ready,  1);
    tick();
    m_valid = 1'b0;
    #1;
    check("t3_head_x3", rf_waddr, 3);
    check("t3_data_x3", rf_wdata, 32'h103);
    tick();
    check("t3_drained", rf_wen,  0);
    check("t3_instret", instret, 6);

    // Start full, then stream ten entries at one per cycle
    rf_ready = 1'b0;
    push_item(1'b1, 5'd10, 32'hA0);
    push_item(1'b1, 5'd11, 32'hA1);
    rf_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10; i++) push_item(1'b1, AW'(12 + i), $urandom);
    check("t4_stream_cycles", cyc - c0, 11);
    repeat (3) tick();
    check("t4_instret", instret, 18);

    // Two pending writes to x4, then reset mid-cycle
    rf_ready = 1'b0;
    push_item(1'b1, 5'd4, 32'hA);
    push_item(1'b1, 5'd4, 32'hB);
    q_addr = 5'd4;
    #1;
`ifdef WB_FWD_EN
    check("t5_hit_x4",  q_hit,  1);
    check("t5_data_x4", q_data, 32'hB);
`else
    check("t5_hit_off",  q_hit,  0);
    check("t5_data_off", q_data, 0);
`endif
    q_addr = 5'd0;
    #1;
    check("t5_hit_x0",   q_hit,  0);
    check("t6_wen_pre",  rf_wen, 1);
    #1;
    rst = 1'b1;
    mq.delete();
    m_instret = '0;
    #1;
    check("t6_wen_rst",     rf_wen,  0);
    check("t6_instret_rst", instret, 0);
    check("t6_ready_rst",   m_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_ready_after", m_ready, 1);
    check("t6_empty_after", rf_wen,  0);

    // Randomised traffic with small address range and occasional resets
    for (int c = 0; c < 3000; c++) begin
      m_valid   = ($urandom_range(0, 3) != 0);
      m_regW    = ($urandom_range(0, 4) != 0);
      m_regAddr = AW'($urandom_range(0, 7));
      m_regData = $urandom;
      rf_ready  = ($urandom_range(0, 3) != 0);
      q_addr    = AW'($urandom_range(0, 7));
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b1;
        mq.delete();
        m_instret = '0;
      end
      tick();
    end

    rst      = 1'b0;
    m_valid  = 1'b0;
    rf_ready = 1'b1;
    repeat (4) tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
